hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
//
// PURPOSE
// Pipeline hazard controller for the ECAP5-DPROC core; next-generation hazard unit.
// - Control hazards: flushes in-flight instructions for a parametrised number of cycles after a taken branch.
// - Load-use hazards: stalls front stages and inserts execute bubbles for a parametrised number of cycles.
// - Memory stalls: freezes the whole pipeline while the LSU waits on the bus.
// Sits beside fetch/decode/execute/loadstore; all outputs go to stage enable/discard logic.
//
// PARAMETERS
// DISCARD_CYCLES    2  cycles control_discard_o stays high per taken branch (>=1)
// LOAD_STALL_CYCLES 1  cycles data_stall_o stays high per load-use hit (>=1)
//
// PORTS
// clk_i             in   1  clock, all state on rising edge
// rst_i             in   1  synchronous reset, active-low
// branch_i          in   1  taken branch/jump resolved in execute, 1-cycle pulse
// dec_rs1_i         in   5  decode-stage source register 1 index
// dec_rs2_i         in   5  decode-stage source register 2 index
// dec_rs1_used_i    in   1  decode instruction reads rs1
// dec_rs2_used_i    in   1  decode instruction reads rs2
// ex_load_i         in   1  execute-stage instruction is a load
// ex_rd_i           in   5  execute-stage destination register index
// mem_busy_i        in   1  loadstore waiting for bus ack
// control_discard_o out  1  invalidate fetch/decode outputs (control hazard)
// data_stall_o      out  1  hold fetch/decode, inject NOP into execute
// mem_stall_o       out  1  freeze all stages
//
// BEHAVIOUR
// - Reset (rst_i=0 at clock edge): disc_cnt=0, stall_cnt=0. While rst_i=0 all outputs are forced to 0.
// - mem_stall_o = mem_busy_i (combinational, 0-cycle latency).
// - Discard counter disc_cnt, width $clog2(DISCARD_CYCLES+1):
//   - control_discard_o = (branch_i & ~mem_busy_i) | (disc_cnt != 0).
//   - Branch with ~mem_busy_i: disc_cnt <= DISCARD_CYCLES-1. Branch during active discard reloads (restart); no accumulation.
//   - Otherwise, if disc_cnt != 0 and ~mem_busy_i: disc_cnt decrements.
//   - mem_busy_i=1: disc_cnt holds; branch_i is ignored (execute is frozen and re-presents it).
//   - Net effect: discard covers exactly DISCARD_CYCLES non-frozen cycles, including the branch cycle.
// - Load-use hit (combinational):
//   - hit = ex_load_i & (ex_rd_i!=0) & ((dec_rs1_used_i & dec_rs1_i==ex_rd_i) | (dec_rs2_used_i & dec_rs2_i==ex_rd_i)).
//   - x0 is never a hazard.
// - Stall counter stall_cnt, width $clog2(LOAD_STALL_CYCLES+1):
//   - data_stall_o = ~control_discard_o & ~mem_busy_i & (hit | stall_cnt != 0).
//   - On hit, when stall_cnt=0 and not suppressed: stall_cnt <= LOAD_STALL_CYCLES-1.
//   - Else if stall_cnt != 0 and ~mem_busy_i: stall_cnt decrements.
//   - mem_busy_i=1: stall_cnt holds.
//   - A discard clears stall_cnt to 0 (the stalled instruction is flushed).
// - Priority: mem_stall_o > control_discard_o > data_stall_o. At most one of control_discard_o/data_stall_o is high in any cycle.
// - Reset mid-operation: both counters cleared on the next edge; no residual discard or stall after rst_i returns to 1.
//
// TESTING
// 1. Reset: rst_i=0 with branch_i=1, ex_load_i=1 -> all outputs 0. Release -> outputs 0 with idle inputs.
// 2. DISCARD_CYCLES=3: branch_i pulse at cycle 0 -> control_discard_o=1 cycles 0..2, 0 at cycle 3.
//    Second branch at cycle 1 -> high through cycle 3.
// 3. Branch at cycle 0, mem_busy_i=1 cycles 1..2, DISCARD_CYCLES=2 -> discard high cycles 0..3
//    (frozen cycles do not count), mem_stall_o=1 cycles 1..2.
// 4. ex_load_i=1, ex_rd_i=5, dec_rs2_i=5, dec_rs2_used_i=1, LOAD_STALL_CYCLES=2 -> data_stall_o=1 for 2 cycles.
//    Same with ex_rd_i=0, or dec_rs2_used_i=0 -> data_stall_o=0.
// 5. Load-use hit and branch_i in same cycle -> control_discard_o=1, data_stall_o=0, stall_cnt stays 0.
// 6. Random stimulus 10k cycles vs reference model; assert control_discard_o & data_stall_o never both 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: control-hazard discard, load-use stall and
// memory freeze for the ECAP5-DPROC stages.
module hazard_ctrl #(
  parameter int DISCARD_CYCLES    = 2,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       branch_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic       dec_rs1_used_i,
  input  logic       dec_rs2_used_i,
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_busy_i,
  output logic       control_discard_o,
  output logic       data_stall_o,
  output logic       mem_stall_o
);

  localparam int DISC_W  = $clog2(DISCARD_CYCLES + 1);
  localparam int STALL_W = $clog2(LOAD_STALL_CYCLES + 1);

  localparam logic [DISC_W-1:0]  DISC_LOAD  = DISC_W'(DISCARD_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [DISC_W-1:0]  DISC_ONE   = DISC_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [DISC_W-1:0]  disc_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               hit;
  logic               discard;
  logic               stall;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hit = ex_load_i & (ex_rd_i != 5'd0) &
               ((dec_rs1_used_i & (dec_rs1_i == ex_rd_i)) |
                (dec_rs2_used_i & (dec_rs2_i == ex_rd_i)));

  assign discard = (branch_i & ~mem_busy_i) | (disc_cnt != '0);
  assign stall   = ~discard & ~mem_busy_i & (hit | (stall_cnt != '0));

  assign mem_stall_o       = rst_i & mem_busy_i;
  assign control_discard_o = rst_i & discard;
  assign data_stall_o      = rst_i & stall;

  // While the bus is busy, execute is frozen and will re-present the branch
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      disc_cnt <= '0;
    end else if (!mem_busy_i) begin
      if (branch_i) begin
        disc_cnt <= DISC_LOAD;
      end else if (disc_cnt != '0) begin
        disc_cnt <= disc_cnt - DISC_ONE;
      end
    end
  end

  // A discard flushes the stalled instruction, so pending stall cycles are dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (discard) begin
      stall_cnt <= '0;
    end else if (!mem_busy_i) begin
      if (hit && (stall_cnt == '0)) begin
        stall_cnt <= STALL_LOAD;
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vector table, multi-cycle corner
// sequences and a randomised comparison against a behavioural model.
module tb_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       branch;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       load;
    logic [4:0] rd;
    logic       busy;
    logic       e_disc;
    logic       e_stall;
    logic       e_mem;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       ex_load;
  logic [4:0] ex_rd;
  logic       mem_busy;
  logic       disc3, stall3, mem3;
  logic       disc2, stall2, mem2;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.DISCARD_CYCLES(3), .LOAD_STALL_CYCLES(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .branch_i(branch),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
    .ex_load_i(ex_load), .ex_rd_i(ex_rd), .mem_busy_i(mem_busy),
    .control_discard_o(disc3), .data_stall_o(stall3), .mem_stall_o(mem3)
  );

  hazard_ctrl #(.DISCARD_CYCLES(2), .LOAD_STALL_CYCLES(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .branch_i(branch),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
    .ex_load_i(ex_load), .ex_rd_i(ex_rd), .mem_busy_i(mem_busy),
    .control_discard_o(disc2), .data_stall_o(stall2), .mem_stall_o(mem2)
  );

  function automatic vec_t mkVec(input logic r, b, input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2, input logic ld,
                                 input logic [4:0] d, input logic bz,
                                 input logic ed, es, em);
    vec_t v;
    v.rst = r; v.branch = b; v.rs1 = s1; v.u1 = u1; v.rs2 = s2; v.u2 = u2;
    v.load = ld; v.rd = d; v.busy = bz; v.e_disc = ed; v.e_stall = es; v.e_mem = em;
    return v;
  endfunction

  // Drives one cycle of inputs just after a falling edge; the next rising edge commits them
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; branch = v.branch; dec_rs1 = v.rs1; rs1_used = v.u1;
    dec_rs2 = v.rs2; rs2_used = v.u2; ex_load = v.load; ex_rd = v.rd; mem_busy = v.busy;
    #2;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic modelStep(input int dmax, input int lmax, inout int dc, inout int sc,
                           output logic ed, output logic es, output logic em);
    logic h;
    h = ex_load && (ex_rd != 0) &&
        ((rs1_used && dec_rs1 == ex_rd) || (rs2_used && dec_rs2 == ex_rd));
    if (!rst) begin
      ed = 0; es = 0; em = 0; dc = 0; sc = 0;
    end else begin
      em = mem_busy;
      ed = (branch && !mem_busy) || (dc != 0);
      es = !ed && !mem_busy && (h || sc != 0);
      if (!mem_busy) begin
        if (branch) begin
          dc = dmax - 1; sc = 0;
        end else if (dc != 0) begin
          dc = dc - 1; sc = 0;
        end else if (sc == 0 && h) begin
          sc = lmax - 1;
        end else if (sc != 0) begin
          sc = sc - 1;
        end
      end
    end
  endtask

  initial begin
    int dc3, sc3, dc2, sc2;
    logic ed, es, em;
    rst = 0; branch = 0; dec_rs1 = 0; dec_rs2 = 0; rs1_used = 0; rs2_used = 0;
    ex_load = 0; ex_rd = 0; mem_busy = 0;

    // Table for the DISCARD_CYCLES=3 / LOAD_STALL_CYCLES=2 instance
    //                   r  b  rs1 u1 rs2 u2 ld rd bz   disc stall mem
    vecs.push_back(mkVec(0, 1, 0, 0, 5, 1, 1, 5, 1,   0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 5, 1, 1, 5, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 5, 1, 1, 5, 0,   0, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 5, 0, 1, 5, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 7, 1, 0, 0, 1, 7, 0,   0, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 5, 1, 1, 5, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 5, 1, 1, 5, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 5, 1, 1, 5, 0,   0, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 5, 1, 1, 5, 0,   0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput("vec_discard", i, disc3, vecs[i].e_disc);
      checkOutput("vec_stall", i, stall3, vecs[i].e_stall);
      checkOutput("vec_mem", i, mem3, vecs[i].e_mem);
    end

    // DISCARD_CYCLES=2: frozen cycles do not consume the discard window
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("frz_reset", 0, disc2, 1'b0);
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("frz_disc", 1, disc2, 1'b1);
    checkOutput("frz_mem", 1, mem2, 1'b0);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    checkOutput("frz_disc", 2, disc2, 1'b1);
    checkOutput("frz_mem", 2, mem2, 1'b1);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    checkOutput("frz_disc", 3, disc2, 1'b1);
    checkOutput("frz_mem", 3, mem2, 1'b1);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("frz_disc", 4, disc2, 1'b1);
    checkOutput("frz_mem", 4, mem2, 1'b0);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("frz_disc", 5, disc2, 1'b0);
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    checkOutput("busy_branch_disc", 6, disc2, 1'b0);
    checkOutput("busy_branch_mem", 6, mem2, 1'b1);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("busy_branch_disc", 7, disc2, 1'b0);
    applyStimulus(mkVec(1, 0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0));
    checkOutput("stall1_stall", 8, stall2, 1'b1);
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("stall1_stall", 9, stall2, 1'b0);

    // Random comparison of both instances against the behavioural model
    dc3 = 0; sc3 = 0; dc2 = 0; sc2 = 0;
    for (int i = 0; i < 10000; i++) begin
      vec_t v;
      v = mkVec(i == 0 ? 1'b0 : ($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), 0, 0, 0);
      applyStimulus(v);
      modelStep(3, 2, dc3, sc3, ed, es, em);
      checkOutput("rnd3_disc", i, disc3, ed);
      checkOutput("rnd3_stall", i, stall3, es);
      checkOutput("rnd3_mem", i, mem3, em);
      modelStep(2, 1, dc2, sc2, ed, es, em);
      checkOutput("rnd2_disc", i, disc2, ed);
      checkOutput("rnd2_stall", i, stall2, es);
      checkOutput("rnd2_mem", i, mem2, em);
      checkOutput("rnd3_exclusive", i, disc3 & stall3, 1'b0);
      checkOutput("rnd2_exclusive", i, disc2 & stall2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
